// File: rtl/dac_out_pkg.sv
// dac_out_pkg: shared types and helpers for the DAC output switch.
//   state_t  - switch FSM encoding
//   SEL_*    - output_select source codes
//   sat16    - clip an 18-bit signed sum into the 16-bit signed range
package dac_out_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    SWAP      = 2'd2,
    RAMP_UP   = 2'd3
  } state_t;

  localparam logic [4:0] SEL_MUTE = 5'd0;
  localparam logic [4:0] SEL_DAC1 = 5'd1;
  localparam logic [4:0] SEL_DAC2 = 5'd2;
  localparam logic [4:0] SEL_DAC3 = 5'd3;
  localparam logic [4:0] SEL_SUM  = 5'd4;
  localparam logic [4:0] SEL_TEST = 5'd5;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] s);
    if (s > 18'sd32767)
      return 16'sh7fff;
    else if (s < 18'sh38000)  // -32768 in 18 bits
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

endpackage

// File: rtl/dac_lane_scale.sv
// dac_lane_scale: one 16-bit lane of the DAC output path.
//   Stage 1 registers the selected source (one stream, the clipped three-way
//   sum, the test pattern, or zero). Stage 2 registers
//   (src * gain) >>> RAMP_SHIFT, which floors and is exact at gain = 2^RAMP_SHIFT.
// Ports:
//   clock, reset    sample clock, async active-high reset
//   sel             source code for stage 1 (the top's active_select)
//   gain            gain already delayed one cycle to line up with stage 1
//   d1, d2, d3      signed lane samples of the three streams
//   pat             test-pattern word (only with DAC_OUT_TEST_PATTERN_EN)
//   out             scaled lane output
// Macro: DAC_OUT_TEST_PATTERN_EN makes code 5 select pat; otherwise it mutes.
module dac_lane_scale
  import dac_out_pkg::*;
#(
  parameter int RAMP_SHIFT = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            sel,
  input  logic [RAMP_SHIFT:0]   gain,
  input  logic signed [15:0]    d1,
  input  logic signed [15:0]    d2,
  input  logic signed [15:0]    d3,
`ifdef DAC_OUT_TEST_PATTERN_EN
  input  logic [15:0]           pat,
`endif
  output logic signed [15:0]    out
);

  localparam int PW = 16 + RAMP_SHIFT + 2;

  logic signed [17:0]   sum;
  logic signed [15:0]   src_d, src_q;
  logic signed [15:0]   out_d, out_q;
  logic signed [PW-1:0] src_ext, gain_ext;

  always_comb begin
    sum = {{2{d1[15]}}, d1} + {{2{d2[15]}}, d2} + {{2{d3[15]}}, d3};
    src_d = '0;
    case (sel)
      SEL_MUTE: src_d = '0;
      SEL_DAC1: src_d = d1;
      SEL_DAC2: src_d = d2;
      SEL_DAC3: src_d = d3;
      SEL_SUM:  src_d = sat16(sum);
`ifdef DAC_OUT_TEST_PATTERN_EN
      SEL_TEST: src_d = pat;
`else
      SEL_TEST: src_d = '0;
`endif
      default:  src_d = '0;
    endcase
  end

  always_comb begin
    src_ext  = {{(PW-16){src_q[15]}}, src_q};
    gain_ext = {{(PW-RAMP_SHIFT-1){1'b0}}, gain};
    out_d    = 16'((src_ext * gain_ext) >>> RAMP_SHIFT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      out_q <= '0;
    end else begin
      src_q <= src_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/dac_output_switch.sv
// dac_output_switch: click-free source selector in front of the DAC.
//   Any change of source ramps the gain down to zero, swaps the source, then
//   ramps the gain back up. Gain, source and code move together through the
//   2-stage lane datapath.
// Ports:
//   clock, reset     sample clock, async active-high reset
//   output_select    requested source code (0 mute, 1..3 stream, 4 sum, 5 test)
//   dac1/2/3_data    NUMBER_OF_LINE signed 16-bit lanes each, lane k = [16k+15:16k]
//   dac_data_out     scaled selected source
//   active_select    code currently feeding the datapath
//   switch_busy      high whenever the FSM is not IDLE
// Macro: DAC_OUT_TEST_PATTERN_EN adds the 16-bit sawtooth counter for code 5.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | gain parked; waits for sel_q to differ from active_select
// RAMP_DOWN | gain falls by one per cycle; a revert turns it into RAMP_UP
// SWAP      | gain is zero; active_select takes the latest sel_q
// RAMP_UP   | gain rises by one per cycle to full scale; a new request turns
//           | it back into RAMP_DOWN from the current gain
module dac_output_switch
  import dac_out_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int RAMP_SHIFT     = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4:0]                   output_select,
  input  logic [16*NUMBER_OF_LINE-1:0] dac1_data,
  input  logic [16*NUMBER_OF_LINE-1:0] dac2_data,
  input  logic [16*NUMBER_OF_LINE-1:0] dac3_data,
  output logic [16*NUMBER_OF_LINE-1:0] dac_data_out,
  output logic [4:0]                   active_select,
  output logic                         switch_busy
);

  localparam logic [RAMP_SHIFT:0] G_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [RAMP_SHIFT:0] G_ONE  = {{RAMP_SHIFT{1'b0}}, 1'b1};

  logic [4:0]          sel_d, sel_q;
  state_t              state_d, state_q;
  logic [RAMP_SHIFT:0] gain_d, gain_q;
  logic [RAMP_SHIFT:0] gain_dp_q;
  logic [4:0]          active_d, active_q;

  assign sel_d = output_select;

  // Transitions fire on the cycle that lands gain on its end value, so a full
  // switch costs G_FULL cycles down, one SWAP cycle and G_FULL cycles up.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (sel_q != active_q) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (sel_q == active_q) begin
          state_d = RAMP_UP;
        end else if (gain_q == '0) begin
          state_d = SWAP;
        end else begin
          gain_d = gain_q - G_ONE;
          if (gain_q == G_ONE) state_d = SWAP;
        end
      end
      SWAP: begin
        active_d = sel_q;
        state_d  = RAMP_UP;
      end
      RAMP_UP: begin
        if (sel_q != active_q) begin
          state_d = RAMP_DOWN;
        end else if (gain_q == G_FULL) begin
          state_d = IDLE;
        end else begin
          gain_d = gain_q + G_ONE;
          if (gain_q == G_FULL - G_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // gain_dp_q delays the gain by one cycle so it meets the registered source.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      state_q   <= IDLE;
      gain_q    <= '0;
      gain_dp_q <= '0;
      active_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      state_q   <= state_d;
      gain_q    <= gain_d;
      gain_dp_q <= gain_q;
      active_q  <= active_d;
    end
  end

`ifdef DAC_OUT_TEST_PATTERN_EN
  logic [15:0] pat_cnt_d, pat_cnt_q;

  assign pat_cnt_d = pat_cnt_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pat_cnt_q <= '0;
    else       pat_cnt_q <= pat_cnt_d;
  end
`endif

  for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_lane
`ifdef DAC_OUT_TEST_PATTERN_EN
    logic [15:0] pat_word;
    assign pat_word = pat_cnt_q * 16'(NUMBER_OF_LINE) + 16'(k);
`endif
    dac_lane_scale #(.RAMP_SHIFT(RAMP_SHIFT)) u_lane (
      .clock (clock),
      .reset (reset),
      .sel   (active_q),
      .gain  (gain_dp_q),
      .d1    (dac1_data[16*k +: 16]),
      .d2    (dac2_data[16*k +: 16]),
      .d3    (dac3_data[16*k +: 16]),
`ifdef DAC_OUT_TEST_PATTERN_EN
      .pat   (pat_word),
`endif
      .out   (dac_data_out[16*k +: 16])
    );
  end

  assign active_select = active_q;
  assign switch_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dac_output_switch.sv
module tb_dac_output_switch;

  localparam int N = 8;
  localparam int W = 16 * N;

  logic         clock = 1'b0;
  logic         reset;
  logic [4:0]   output_select;
  logic [W-1:0] dac1_data, dac2_data, dac3_data;
  logic [W-1:0] dac_data_out;
  logic [4:0]   active_select;
  logic         switch_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dac_output_switch #(.NUMBER_OF_LINE(N), .RAMP_SHIFT(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .output_select (output_select),
    .dac1_data     (dac1_data),
    .dac2_data     (dac2_data),
    .dac3_data     (dac3_data),
    .dac_data_out  (dac_data_out),
    .active_select (active_select),
    .switch_busy   (switch_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(output logic [W-1:0] v, input int val);
    for (int k = 0; k < N; k++) v[16*k +: 16] = 16'(val);
  endtask

  // Request a code and wait (bounded) until the switch is idle and the
  // full-gain value has crossed the 2-stage datapath.
  task automatic settle(input logic [4:0] code);
    int t;
    output_select = code;
    tick(); tick(); tick();
    t = 0;
    while (switch_busy && t < 300) begin
      tick();
      t++;
    end
    n_cmp++;
    if (switch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL settle_timeout code=%0d busy=%b expected 0", code, switch_busy);
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      output_select = 5'($urandom);
      dac1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      dac2_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      dac3_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    n_cmp++;
    if (dac_data_out !== '0) begin
      n_err++;
      $display("FAIL reset_out got %h expected 0", dac_data_out);
    end
    n_cmp++;
    if (active_select !== 5'd0) begin
      n_err++;
      $display("FAIL reset_active got %0d expected 0", active_select);
    end
    n_cmp++;
    if (switch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got %b expected 0", switch_busy);
    end
  endtask

  task automatic test_select_dac1();
    logic [W-1:0] expv;
    int g, first_act;
    logic exp_busy;
    fill(dac1_data, 1000);
    fill(dac2_data, -2222);
    fill(dac3_data, 3333);
    reset = 1'b0;
    output_select = 5'd1;
    first_act = -1;
    for (int k = 1; k <= 72; k++) begin
      tick();
      // out at edge k uses the gain from edge k-2; the gain reads k-4 from edge 4
      g = k - 6;
      if (g < 0) g = 0;
      if (g > 64) g = 64;
      fill(expv, (1000 * g) / 64);
      n_cmp++;
      if (dac_data_out !== expv) begin
        n_err++;
        $display("FAIL dac1_ramp k=%0d got %h expected %h", k, dac_data_out, expv);
      end
      exp_busy = (k >= 2 && k <= 67);
      n_cmp++;
      if (switch_busy !== exp_busy) begin
        n_err++;
        $display("FAIL dac1_busy k=%0d got %b expected %b", k, switch_busy, exp_busy);
      end
      if (active_select == 5'd1 && first_act < 0) first_act = k;
    end
    n_cmp++;
    if (first_act !== 4) begin
      n_err++;
      $display("FAIL dac1_active_latency got %0d expected 4", first_act);
    end
  endtask

  task automatic test_saturated_sum();
    int v1[5] = '{20000, -20000, 100, 30000, -30000};
    int v2[5] = '{20000, -20000, -300, 2767, -2768};
    int v3[5] = '{20000, -20000, 50, 1, 0};
    int ve[5] = '{32767, -32768, -150, 32767, -32768};
    logic [W-1:0] expv;
    for (int i = 0; i < 5; i++) begin
      fill(dac1_data, v1[i]);
      fill(dac2_data, v2[i]);
      fill(dac3_data, v3[i]);
      if (i == 0) settle(5'd4);
      else begin tick(); tick(); end
      fill(expv, ve[i]);
      n_cmp++;
      if (dac_data_out !== expv) begin
        n_err++;
        $display("FAIL sum_vec%0d got %h expected %h", i, dac_data_out, expv);
      end
    end
    n_cmp++;
    if (active_select !== 5'd4) begin
      n_err++;
      $display("FAIL sum_active got %0d expected 4", active_select);
    end
    for (int k = 0; k < N; k++) begin
      dac1_data[16*k +: 16] = 16'(1000 * k);
      expv[16*k +: 16]      = 16'(1000 * k - 493);
    end
    fill(dac2_data, -500);
    fill(dac3_data, 7);
    tick(); tick();
    n_cmp++;
    if (dac_data_out !== expv) begin
      n_err++;
      $display("FAIL sum_per_lane got %h expected %h", dac_data_out, expv);
    end
  endtask

  task automatic test_revert();
    logic [W-1:0] expv;
    logic signed [15:0] lv;
    int minv, bad_act;
    fill(dac1_data, 1000);
    fill(dac2_data, -2222);
    fill(dac3_data, 3333);
    settle(5'd1);
    fill(expv, 1000);
    n_cmp++;
    if (dac_data_out !== expv) begin
      n_err++;
      $display("FAIL revert_start got %h expected %h", dac_data_out, expv);
    end
    output_select = 5'd2;
    minv = 32767;
    bad_act = 0;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 34) output_select = 5'd1;
      lv = $signed(dac_data_out[15:0]);
      if (int'(lv) < minv) minv = int'(lv);
      if (active_select != 5'd1) bad_act++;
      if (k == 68) begin
        n_cmp++;
        if (switch_busy !== 1'b1) begin
          n_err++;
          $display("FAIL revert_busy68 got %b expected 1", switch_busy);
        end
      end
      if (k == 69) begin
        n_cmp++;
        if (switch_busy !== 1'b0) begin
          n_err++;
          $display("FAIL revert_busy69 got %b expected 0", switch_busy);
        end
      end
    end
    // deepest gain is 31 -> floor(31000/64)
    n_cmp++;
    if (minv !== 484) begin
      n_err++;
      $display("FAIL revert_min got %0d expected 484", minv);
    end
    n_cmp++;
    if (bad_act !== 0) begin
      n_err++;
      $display("FAIL revert_active_moved got %0d cycles expected 0", bad_act);
    end
    n_cmp++;
    if (dac_data_out !== expv) begin
      n_err++;
      $display("FAIL revert_end got %h expected %h", dac_data_out, expv);
    end
  endtask

  task automatic test_change_during_rampdown();
    logic [W-1:0] expv;
    int bad_act, neg;
    output_select = 5'd2;
    bad_act = 0;
    neg = 0;
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (k == 10) output_select = 5'd3;
      if (active_select == 5'd2) bad_act++;
      for (int j = 0; j < N; j++)
        if (dac_data_out[16*j + 15]) neg++;
    end
    n_cmp++;
    if (bad_act !== 0) begin
      n_err++;
      $display("FAIL chg_active_was_2 got %0d cycles expected 0", bad_act);
    end
    n_cmp++;
    if (neg !== 0) begin
      n_err++;
      $display("FAIL chg_stream2_seen got %0d negative lanes expected 0", neg);
    end
    n_cmp++;
    if (active_select !== 5'd3 || switch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL chg_final active=%0d busy=%b expected 3/0", active_select, switch_busy);
    end
    fill(expv, 3333);
    n_cmp++;
    if (dac_data_out !== expv) begin
      n_err++;
      $display("FAIL chg_out got %h expected %h", dac_data_out, expv);
    end
  endtask

  task automatic test_test_pattern();
    settle(5'd5);
    n_cmp++;
    if (active_select !== 5'd5) begin
      n_err++;
      $display("FAIL pat_active got %0d expected 5", active_select);
    end
`ifdef DAC_OUT_TEST_PATTERN_EN
    begin
      logic [15:0] w0, w1, expw;
      for (int r = 0; r < 2; r++) begin
        w0 = dac_data_out[15:0];
        for (int k = 1; k < N; k++) begin
          expw = w0 + 16'(k);
          n_cmp++;
          if (dac_data_out[16*k +: 16] !== expw) begin
            n_err++;
            $display("FAIL pat_lane%0d got %h expected %h", k, dac_data_out[16*k +: 16], expw);
          end
        end
        tick();
        w1 = dac_data_out[15:0];
        expw = w0 + 16'd8;
        n_cmp++;
        if (w1 !== expw) begin
          n_err++;
          $display("FAIL pat_step got %h expected %h", w1, expw);
        end
      end
    end
`else
    n_cmp++;
    if (dac_data_out !== '0) begin
      n_err++;
      $display("FAIL pat_disabled_out got %h expected 0", dac_data_out);
    end
`endif
  endtask

  task automatic test_mute_codes();
    logic [4:0] codes[3] = '{5'd0, 5'd9, 5'd31};
    for (int i = 0; i < 3; i++) begin
      settle(codes[i]);
      n_cmp++;
      if (dac_data_out !== '0 || active_select !== codes[i]) begin
        n_err++;
        $display("FAIL mute_code%0d out=%h active=%0d expected 0/%0d",
                 codes[i], dac_data_out, active_select, codes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    output_select = 5'd1;
    for (int k = 0; k < 40; k++) tick();
    n_cmp++;
    if (switch_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre_busy got %b expected 1", switch_busy);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (dac_data_out !== '0 || active_select !== 5'd0 || switch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async out=%h active=%0d busy=%b expected 0/0/0",
               dac_data_out, active_select, switch_busy);
    end
    tick(); tick();
    output_select = 5'd0;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (dac_data_out !== '0 || switch_busy !== 1'b0 || active_select !== 5'd0) begin
      n_err++;
      $display("FAIL midrst_after out=%h busy=%b active=%0d expected 0/0/0",
               dac_data_out, switch_busy, active_select);
    end
  endtask

  initial begin
    test_reset();
    test_select_dac1();
    test_saturated_sum();
    test_revert();
    test_change_during_rampdown();
    test_test_pattern();
    test_mute_codes();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
